// File: rtl/regs_bank_pkg.sv
// Shared definitions for the register bank: channel map helpers,
// register width derivation and strobe decoding.
package regs_bank_pkg;

  // Widest strobe bus the decoding helpers accept.
  localparam int MAX_CH = 64;

  // Input channels always start at channel 0.
  localparam int CH_IN0 = 0;

  function automatic int reg_w(input int bytes);
    return 8 * bytes;
  endfunction

  // First read/write output register follows the input channels.
  function automatic int ch_out0(input int n_in);
    return n_in;
  endfunction

  // IO data channel follows the last output register.
  function automatic int ch_iod(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  // IO Z-state channel is the last channel of the map.
  function automatic int ch_ioz(input int n_in, input int n_out);
    return n_in + n_out + 1;
  endfunction

  function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  // Index of the highest set bit; meaningful only for a one-hot input.
  function automatic logic [5:0] onehot_to_idx(input logic [MAX_CH-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regs_bank_if.sv
// Byte-stream link between the protocol decoder (master) and the bank (slave).
//
// Strobe semantics: valid_bus is a per-channel byte strobe, one-hot, and
// master_data is captured on any clock edge where it is set. rdreq_bus
// consumes the current slave_data byte on any edge where any bit is set.
// There is no ready: the bank accepts every strobe in the cycle it appears,
// and flags protocol misuse on its error strobe instead of stalling.
interface regs_bank_if #(
  parameter int N = 27
);
  logic [7:0]   master_data;
  logic [N-1:0] valid_bus;
  logic [N-1:0] rdreq_bus;
  logic [N-1:0] have_msg_bus;
  logic [7:0]   len;
  logic [7:0]   slave_data;

  modport master (
    output master_data, valid_bus, rdreq_bus,
    input  have_msg_bus, len, slave_data
  );

  modport slave (
    input  master_data, valid_bus, rdreq_bus,
    output have_msg_bus, len, slave_data
  );
endinterface

// File: rtl/regs_bank_sync2.sv
// Generic-width two-flop synchroniser for asynchronous inputs.
module regs_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/regs_bank.sv
// Parametrised register bank: synchronised inputs, read/write outputs and a
// GPIO group, written byte-serially (LSB first) and read back from a snapshot.
module regs_bank
  import regs_bank_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 21,
  parameter int N_IO      = 3,
  parameter int REG_BYTES = 2,
  parameter logic [N_OUT*8*REG_BYTES-1:0] OUT_RST = '0
) (
  input  logic                          clk,
  input  logic                          n_rst,
  regs_bank_if.slave                    bus,
  input  logic [N_IN*8*REG_BYTES-1:0]   in_bus,
  output logic [N_OUT*8*REG_BYTES-1:0]  out_bus,
  inout  wire  [N_IO-1:0]               gpio_io,
  output logic                          err_pulse
);
  localparam int REG_W   = reg_w(REG_BYTES);
  localparam int N       = N_IN + N_OUT + 2;
  localparam int CH_OUT0 = ch_out0(N_IN);
  localparam int CH_IOD  = ch_iod(N_IN, N_OUT);
  localparam int CH_IOZ  = ch_ioz(N_IN, N_OUT);

  logic [N_OUT*REG_W-1:0] out_q, out_n;
  logic [N_IO-1:0]        io_data_q, io_data_n;
  logic [N_IO-1:0]        io_z_q, io_z_n;
  logic [REG_W-1:0]       shadow_q, shadow_n;
  logic [N-1:0]           have_q, have_n;
  logic [2:0]             rd_ptr_q, rd_ptr_n;
  logic [2:0]             wcnt_q, wcnt_n;
  logic [5:0]             wchan_q, wchan_n;
  logic [REG_W-1:0]       asm_q, asm_n;
  logic                   err_n;

  logic [N_IN*REG_W-1:0]  in_sync;
  logic [N_IO-1:0]        pin_sync;

  regs_sync2 #(.W(N_IN*REG_W)) u_in_sync (
    .clk(clk), .n_rst(n_rst), .d(in_bus), .q(in_sync)
  );

  regs_sync2 #(.W(N_IO)) u_pin_sync (
    .clk(clk), .n_rst(n_rst), .d(gpio_io), .q(pin_sync)
  );

  // Pins are released whenever their Z-control bit is set.
  for (genvar k = 0; k < N_IO; k++) begin : g_pin
    assign gpio_io[k] = io_z_q[k] ? 1'bz : io_data_q[k];
  end

  logic             valid_any, valid_one, rd_any, pending;
  logic [5:0]       vidx;
  logic [7:0]       rd_byte;
  logic [REG_W-1:0] word, in_word;
  logic             restart, commit;
  logic [N-1:0]     vidx_hot;

  assign valid_any = |bus.valid_bus;
  assign valid_one = is_onehot(MAX_CH'(bus.valid_bus));
  assign vidx      = onehot_to_idx(MAX_CH'(bus.valid_bus));
  assign vidx_hot  = {{(N-1){1'b0}}, 1'b1} << vidx;
  assign rd_any    = |bus.rdreq_bus;
  assign pending   = |have_q;

  // Select the readback byte addressed by rd_ptr out of the snapshot.
  always_comb begin
    rd_byte = 8'h00;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (rd_ptr_q == 3'(b)) rd_byte = shadow_q[b*8 +: 8];
    end
  end

  assign bus.slave_data   = pending ? rd_byte : 8'h00;
  assign bus.have_msg_bus = have_q;
  assign bus.len          = 8'(REG_BYTES);
  assign out_bus          = out_q;

  // Next-state: readback advance beats byte assembly; multi-hot is dropped.
  always_comb begin
    out_n     = out_q;
    io_data_n = io_data_q;
    io_z_n    = io_z_q;
    shadow_n  = shadow_q;
    have_n    = have_q;
    rd_ptr_n  = rd_ptr_q;
    wcnt_n    = wcnt_q;
    wchan_n   = wchan_q;
    asm_n     = asm_q;
    err_n     = 1'b0;
    word      = asm_q;
    in_word   = '0;
    restart   = 1'b0;
    commit    = 1'b0;

    if (rd_any) begin
      if (valid_any) err_n = 1'b1;
      if (pending) begin
        if (rd_ptr_q == 3'(REG_BYTES - 1)) begin
          have_n   = '0;
          rd_ptr_n = '0;
        end else begin
          rd_ptr_n = rd_ptr_q + 3'd1;
        end
      end else begin
        err_n = 1'b1;
      end
    end else if (valid_any) begin
      if (!valid_one) begin
        err_n = 1'b1;
      end else if (vidx < 6'(CH_OUT0)) begin
        // Input channel: a strobe is a snapshot request.
        for (int i = 0; i < N_IN; i++) begin
          if (vidx == 6'(CH_IN0 + i)) in_word = in_sync[i*REG_W +: REG_W];
        end
        shadow_n = in_word;
        have_n   = vidx_hot;
        rd_ptr_n = '0;
      end else begin
        restart = (wcnt_q == 3'd0) || (vidx != wchan_q);
        if (restart) begin
          err_n      = (wcnt_q != 3'd0);
          word       = '0;
          word[7:0]  = bus.master_data;
          wchan_n    = vidx;
          wcnt_n     = 3'd1;
          commit     = (REG_BYTES == 1);
        end else begin
          for (int b = 0; b < REG_BYTES; b++) begin
            if (wcnt_q == 3'(b)) word[b*8 +: 8] = bus.master_data;
          end
          wcnt_n = wcnt_q + 3'd1;
          commit = (wcnt_q == 3'(REG_BYTES - 1));
        end
        asm_n = word;
        if (commit) begin
          wcnt_n   = '0;
          have_n   = vidx_hot;
          rd_ptr_n = '0;
          for (int o = 0; o < N_OUT; o++) begin
            if (vidx == 6'(CH_OUT0 + o)) begin
              out_n[o*REG_W +: REG_W] = word;
              shadow_n                = word;
            end
          end
          if (vidx == 6'(CH_IOD)) begin
            io_data_n = word[N_IO-1:0];
            shadow_n  = REG_W'(pin_sync);
          end
          if (vidx == 6'(CH_IOZ)) begin
            io_z_n   = word[N_IO-1:0];
            shadow_n = REG_W'(word[N_IO-1:0]);
          end
        end
      end
    end
  end

  // State registers; reset releases all pins and clears any transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_q     <= OUT_RST;
      io_data_q <= '0;
      io_z_q    <= '1;
      shadow_q  <= '0;
      have_q    <= '0;
      rd_ptr_q  <= '0;
      wcnt_q    <= '0;
      wchan_q   <= '0;
      asm_q     <= '0;
      err_pulse <= 1'b0;
    end else begin
      out_q     <= out_n;
      io_data_q <= io_data_n;
      io_z_q    <= io_z_n;
      shadow_q  <= shadow_n;
      have_q    <= have_n;
      rd_ptr_q  <= rd_ptr_n;
      wcnt_q    <= wcnt_n;
      wchan_q   <= wchan_n;
      asm_q     <= asm_n;
      err_pulse <= err_n;
    end
  end
endmodule

// File: tb/tb_regs_bank.sv
// Self-checking bench for regs_bank: directed scenarios followed by random
// traffic, all compared against a byte-queue reference model.
module tb_regs_bank;
  localparam int N_IN      = 4;
  localparam int N_OUT     = 21;
  localparam int N_IO      = 3;
  localparam int REG_BYTES = 2;
  localparam int REG_W     = 8 * REG_BYTES;
  localparam int N         = N_IN + N_OUT + 2;
  localparam int T_IOD     = N_IN + N_OUT;
  localparam int T_IOZ     = N_IN + N_OUT + 1;
  localparam logic [N_OUT*REG_W-1:0] OUT_RST_TB = {N_OUT{16'h5A3C}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [N_IN*REG_W-1:0]  in_bus;
  wire  [N_OUT*REG_W-1:0] out_bus;
  wire  [N_IO-1:0]        gpio_io;
  wire                    err_pulse;
  logic                   ext_en;
  logic [N_IO-1:0]        ext_val;

  assign gpio_io = ext_en ? ext_val : {N_IO{1'bz}};

  regs_bank_if #(.N(N)) bus ();

  regs_bank #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_IO(N_IO), .REG_BYTES(REG_BYTES),
    .OUT_RST(OUT_RST_TB)
  ) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .in_bus(in_bus),
    .out_bus(out_bus), .gpio_io(gpio_io), .err_pulse(err_pulse)
  );

  // ---------------- reference model ----------------
  logic [REG_W-1:0]      out_m [N_OUT];
  logic [N_IO-1:0]       io_d_m, io_z_m;
  logic [7:0]            exp_q[$];
  logic [7:0]            asm_b[$];
  int                    asm_ch;
  int                    pend_ch;
  logic                  exp_err;
  logic [N_IN*REG_W-1:0] in_d1, in_d2;
  logic [N_IO-1:0]       pin_d1, pin_d2;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic mdl_reset();
    for (int i = 0; i < N_OUT; i++) out_m[i] = OUT_RST_TB[i*REG_W +: REG_W];
    io_d_m = '0;
    io_z_m = '1;
    exp_q.delete();
    asm_b.delete();
    asm_ch  = -1;
    pend_ch = -1;
    exp_err = 1'b0;
    in_d1 = '0; in_d2 = '0; pin_d1 = '0; pin_d2 = '0;
  endtask

  task automatic load_exp(input logic [REG_W-1:0] w);
    exp_q.delete();
    for (int b = 0; b < REG_BYTES; b++) exp_q.push_back(w[b*8 +: 8]);
  endtask

  function automatic logic [N_OUT*REG_W-1:0] exp_out();
    logic [N_OUT*REG_W-1:0] r;
    for (int i = 0; i < N_OUT; i++) r[i*REG_W +: REG_W] = out_m[i];
    return r;
  endfunction

  function automatic logic [N-1:0] hot(input int ch);
    logic [N-1:0] h;
    h = '0;
    h[ch] = 1'b1;
    return h;
  endfunction

  // Apply the bank's rules to the inputs present just before a clock edge.
  task automatic mdl_step();
    logic [N-1:0]          v;
    int                    nv, ch;
    logic [REG_W-1:0]      w, rb;
    logic [N_IN*REG_W-1:0] in_now;
    logic [N_IO-1:0]       pin_now;
    in_now = in_bus;
    for (int k = 0; k < N_IO; k++)
      pin_now[k] = !io_z_m[k] ? io_d_m[k] : (ext_en ? ext_val[k] : 1'b0);
    v  = bus.valid_bus;
    nv = $countones(v);
    exp_err = 1'b0;
    if (bus.rdreq_bus != '0) begin
      if (nv != 0) exp_err = 1'b1;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) pend_ch = -1;
      end else begin
        exp_err = 1'b1;
      end
    end else if (nv > 1) begin
      exp_err = 1'b1;
    end else if (nv == 1) begin
      ch = 0;
      for (int i = 0; i < N; i++) if (v[i]) ch = i;
      if (ch < N_IN) begin
        load_exp(in_d2[ch*REG_W +: REG_W]);
        pend_ch = ch;
      end else begin
        if (asm_b.size() == 0 || ch != asm_ch) begin
          if (asm_b.size() != 0) exp_err = 1'b1;
          asm_b.delete();
          asm_ch = ch;
        end
        asm_b.push_back(bus.master_data);
        if (asm_b.size() == REG_BYTES) begin
          w = '0;
          for (int b = 0; b < REG_BYTES; b++) w[b*8 +: 8] = asm_b[b];
          asm_b.delete();
          rb = '0;
          if (ch < T_IOD) begin
            out_m[ch-N_IN] = w;
            rb = w;
          end else if (ch == T_IOD) begin
            io_d_m = w[N_IO-1:0];
            rb[N_IO-1:0] = pin_d2;
          end else begin
            io_z_m = w[N_IO-1:0];
            rb[N_IO-1:0] = w[N_IO-1:0];
          end
          load_exp(rb);
          pend_ch = ch;
        end
      end
    end
    in_d2 = in_d1; in_d1 = in_now;
    pin_d2 = pin_d1; pin_d1 = pin_now;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check registered outputs, step the model, cross the edge,
  // then check what that edge produced.
  task automatic tick();
    logic [N-1:0] hm;
    hm = (pend_ch >= 0) ? hot(pend_ch) : '0;
    chk("slave_data", 512'(bus.slave_data), 512'((exp_q.size() != 0) ? exp_q[0] : 8'h00));
    chk("have_msg", 512'(bus.have_msg_bus), 512'(hm));
    mdl_step();
    @(posedge clk);
    #1;
    chk("out_bus", 512'(out_bus), 512'(exp_out()));
    chk("err_pulse", 512'(err_pulse), 512'(exp_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.valid_bus = '0;
    bus.rdreq_bus = '0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input int ch, input logic [7:0] d);
    bus.valid_bus   = hot(ch);
    bus.master_data = d;
    tick();
    bus.valid_bus = '0;
  endtask

  task automatic read_byte(input int ch);
    bus.rdreq_bus = hot(ch);
    tick();
    bus.rdreq_bus = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, ch, nb;
    bus.master_data = '0;
    bus.valid_bus   = '0;
    bus.rdreq_bus   = '0;
    in_bus  = '0;
    ext_en  = 1'b0;
    ext_val = '0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    #1;

    // Reset state
    chk("rst_out", 512'(out_bus), 512'(OUT_RST_TB));
    chk("rst_have", 512'(bus.have_msg_bus), 512'(0));
    chk("rst_slave", 512'(bus.slave_data), 512'(8'h00));
    chk("rst_err", 512'(err_pulse), 512'(0));
    chk("rst_pins_released", 512'(dut.io_z_q), 512'(3'b111));
    chk("len", 512'(bus.len), 512'(REG_BYTES));

    // Two-byte write to output 7, then read it back
    send_byte(N_IN+7, 8'h34);
    send_byte(N_IN+7, 8'h12);
    chk("wr_ch7", 512'(out_bus[7*REG_W +: REG_W]), 512'(16'h1234));
    chk("wr_ch7_have", 512'(bus.have_msg_bus), 512'(hot(N_IN+7)));
    chk("rd_ch7_b0", 512'(bus.slave_data), 512'(8'h34));
    read_byte(N_IN+7);
    chk("rd_ch7_b1", 512'(bus.slave_data), 512'(8'h12));
    read_byte(N_IN+7);
    chk("rd_ch7_done", 512'(bus.have_msg_bus), 512'(0));

    // Input snapshot stays coherent while the input moves
    in_bus[1*REG_W +: REG_W] = 16'hBEEF;
    idle(3);
    send_byte(1, 8'h00);
    in_bus[1*REG_W +: REG_W] = 16'h1111;
    chk("in_ch1_b0", 512'(bus.slave_data), 512'(8'hEF));
    read_byte(1);
    chk("in_ch1_b1", 512'(bus.slave_data), 512'(8'hBE));
    read_byte(1);

    // GPIO drive, release, and pin readback
    send_byte(T_IOZ, 8'h00);
    send_byte(T_IOZ, 8'h00);
    send_byte(T_IOD, 8'h05);
    send_byte(T_IOD, 8'h00);
    chk("pins_101", 512'(gpio_io), 512'(3'b101));
    send_byte(T_IOZ, 8'h07);
    send_byte(T_IOZ, 8'h00);
    ext_en = 1'b1;
    ext_val = 3'b010;
    idle(3);
    send_byte(T_IOD, 8'h00);
    send_byte(T_IOD, 8'h00);
    chk("iod_rd", 512'(bus.slave_data), 512'(8'h02));

    // Collision: rdreq wins over valid while a message is pending
    bus.valid_bus   = hot(N_IN+2);
    bus.master_data = 8'h77;
    bus.rdreq_bus   = hot(T_IOD);
    tick();
    bus.valid_bus = '0;
    bus.rdreq_bus = '0;
    chk("collide_err", 512'(err_pulse), 512'(1));
    read_byte(T_IOD);

    // Abort: switching channel mid-assembly restarts on the new one
    send_byte(N_IN, 8'hAA);
    send_byte(N_IN+1, 8'h11);
    chk("abort_err", 512'(err_pulse), 512'(1));
    chk("abort_ch0", 512'(out_bus[0 +: REG_W]), 512'(OUT_RST_TB[0 +: REG_W]));
    send_byte(N_IN+1, 8'h22);
    chk("abort_ch1", 512'(out_bus[1*REG_W +: REG_W]), 512'(16'h2211));
    read_byte(N_IN+1);
    read_byte(N_IN+1);

    // Read with nothing pending, and a multi-hot strobe
    read_byte(N_IN+1);
    chk("rd_empty_err", 512'(err_pulse), 512'(1));
    bus.valid_bus   = hot(N_IN+3) | hot(N_IN+4);
    bus.master_data = 8'h99;
    tick();
    bus.valid_bus = '0;
    chk("multihot_err", 512'(err_pulse), 512'(1));

    // Asynchronous reset in the middle of an assembly
    send_byte(N_IN+3, 8'h55);
    n_rst = 1'b0;
    #2;
    chk("arst_out", 512'(out_bus), 512'(OUT_RST_TB));
    chk("arst_have", 512'(bus.have_msg_bus), 512'(0));
    mdl_reset();
    n_rst = 1'b1;
    send_byte(N_IN+3, 8'h66);
    send_byte(N_IN+3, 8'h77);
    chk("arst_ch3", 512'(out_bus[3*REG_W +: REG_W]), 512'(16'h7766));

    // Random traffic against the model
    ext_en  = 1'b1;
    ext_val = 3'b110;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          ch = N_IN + $urandom_range(0, N_OUT-1);
          nb = $urandom_range(1, REG_BYTES);
          for (int b = 0; b < nb; b++) send_byte(ch, 8'($urandom_range(0, 255)));
        end
        1: send_byte($urandom_range(0, N_IN-1), 8'h00);
        2: begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            bus.rdreq_bus = N'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
              bus.valid_bus   = hot(N_IN + $urandom_range(0, N_OUT-1));
              bus.master_data = 8'($urandom_range(0, 255));
            end
            tick();
            bus.rdreq_bus = '0;
            bus.valid_bus = '0;
          end
        end
        3: begin
          in_bus = (N_IN*REG_W)'({$urandom, $urandom});
          idle(1);
        end
        default: begin
          bus.valid_bus   = hot(N_IN + $urandom_range(0, 9)) | hot(N_IN + 10 + $urandom_range(0, 9));
          bus.master_data = 8'($urandom_range(0, 255));
          tick();
          bus.valid_bus = '0;
        end
      endcase
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
